// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the CPU it feeds.
//   INSTR_W        : instruction word width (matches the CPU)
//   loader_state_t : loader FSM states
//   len_ok()       : length check for a start request
package program_loader_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_CLEAR,
    ST_STREAM,
    ST_BOOT,
    ST_RUN
  } loader_state_t;

  // A program must hold at least one word and fit in the buffer.
  function automatic logic len_ok(input int unsigned len, input int unsigned depth);
    return (len != 0) && (len <= depth);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host-side command and word stream of the program loader.
//   start    : one-cycle load request (host -> loader)
//   prog_len : program length in words, sampled with start
//   in_valid : host word valid
//   in_data  : host instruction word
//   in_ready : loader accepts a word this cycle (loader -> host)
interface program_loader_if #(
  parameter int LEN_W = 6
);
  import program_loader_pkg::*;

  logic               start;
  logic [LEN_W-1:0]   prog_len;
  logic               in_valid;
  logic [INSTR_W-1:0] in_data;
  logic               in_ready;

  modport master (output start, prog_len, in_valid, in_data, input in_ready);
  modport slave  (input start, prog_len, in_valid, in_data, output in_ready);

endinterface

// File: rtl/loader_buf.sv
// Program buffer: DEPTH x INSTR_W register array.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (asynchronous read)
//   rdata_o : read data
module loader_buf
  import program_loader_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; every word streamed is written during FILL
  // first, so clearing it would only cost a reset net to every bit.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_loader.sv
// Boot front end for the pipelined CPU: buffers a host program, holds the CPU
// in reset, replays the program into instruction memory without gaps, then
// releases the CPU.
//   clk       : clock, rising edge
//   Reset     : synchronous active-high reset
//   host      : host command/word stream (slave side)
//   cpu_reset : CPU Reset
//   cpu_load  : CPU LoadInstructions
//   cpu_instr : CPU Instruction
//   done      : CPU is running the loaded program
//   err       : sticky, set by a start with an out-of-range length
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int LEN_W      = 6,
  parameter int RST_CYCLES = 2
) (
  input  logic               clk,
  input  logic               Reset,
  program_loader_if.slave    host,
  output logic               cpu_reset,
  output logic               cpu_load,
  output logic [INSTR_W-1:0] cpu_instr,
  output logic               done,
  output logic               err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PH_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(RST_CYCLES - 1);

  loader_state_t      state_q, state_d;
  logic [LEN_W-1:0]   count_q, count_d;  // words accepted in FILL
  logic [LEN_W-1:0]   idx_q, idx_d;      // word presented in STREAM
  logic [LEN_W-1:0]   len_q, len_d;
  logic [PH_W-1:0]    ph_q, ph_d;        // cycles spent in CLEAR / BOOT
  logic               err_q, err_d;
  logic               cpu_reset_q, cpu_load_q, done_q;
  logic [INSTR_W-1:0] cpu_instr_q;

  logic               start_ok;
  logic               wr_en;
  logic [INSTR_W-1:0] buf_rdata;

  assign start_ok = len_ok(32'(host.prog_len), DEPTH);
  assign wr_en    = (state_q == ST_FILL) && host.in_valid;

  // Read address is the next index so the registered cpu_instr lines up with
  // the registered cpu_load.
  loader_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (host.in_data),
    .raddr_i (idx_d[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  // NOTE: every variable gets its hold value first so no path through the
  // case leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    len_d   = len_q;
    ph_d    = ph_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (host.start) begin
          if (start_ok) begin
            len_d   = host.prog_len;
            count_d = '0;
            err_d   = 1'b0;
            state_d = ST_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (host.in_valid) begin
          count_d = count_q + LEN_W'(1);
          if (count_q == len_q - LEN_W'(1)) begin
            ph_d    = '0;
            idx_d   = '0;
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        if (ph_q == PH_LAST) begin
          idx_d   = '0;
          state_d = ST_STREAM;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_STREAM: begin
        if (idx_q == len_q - LEN_W'(1)) begin
          ph_d    = '0;
          state_d = ST_BOOT;
        end else begin
          idx_d = idx_q + LEN_W'(1);
        end
      end
      ST_BOOT: begin
        if (ph_q == PH_LAST) state_d = ST_RUN;
        else                 ph_d    = ph_q + PH_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      ph_q        <= '0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      cpu_load_q  <= 1'b0;
      cpu_instr_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      ph_q        <= ph_d;
      err_q       <= err_d;
      // Outputs are decoded from the next state so they change together
      // with the state register.
      cpu_reset_q <= !((state_d == ST_STREAM) || (state_d == ST_RUN));
      cpu_load_q  <= (state_d == ST_STREAM);
      cpu_instr_q <= (state_d == ST_STREAM) ? buf_rdata : '0;
      done_q      <= (state_d == ST_RUN);
    end
  end

  assign host.in_ready = (state_q == ST_FILL);
  assign cpu_reset     = cpu_reset_q;
  assign cpu_load      = cpu_load_q;
  assign cpu_instr     = cpu_instr_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader. Expected output traces are built
// from the load sequence: RST_CYCLES reset cycles, len load cycles carrying
// the program in order, RST_CYCLES reset cycles, then run.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int DEPTH      = 32;
  localparam int LEN_W      = 6;
  localparam int RST_CYCLES = 2;

  logic               clk = 1'b0;
  logic               Reset;
  logic               cpu_reset, cpu_load, done, err;
  logic [INSTR_W-1:0] cpu_instr;

  program_loader_if #(.LEN_W(LEN_W)) host_if ();

  program_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .host      (host_if),
    .cpu_reset (cpu_reset),
    .cpu_load  (cpu_load),
    .cpu_instr (cpu_instr),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [INSTR_W-1:0] prog [DEPTH];

  typedef struct {
    logic             start;
    logic [LEN_W-1:0] len;
    logic             exp_err;
    logic             exp_ready;
  } vec_t;
  vec_t vecs [5];

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else             n_pass++;
  endtask

  task automatic clear_inputs();
    host_if.start    = 1'b0;
    host_if.prog_len = '0;
    host_if.in_valid = 1'b0;
    host_if.in_data  = '0;
  endtask

  task automatic issue_start(input int len);
    host_if.start    = 1'b1;
    host_if.prog_len = LEN_W'(len);
    step();
    host_if.start = 1'b0;
    check($sformatf("start len%0d {ready,rst,done,err}", len),
          {host_if.in_ready, cpu_reset, done, err}, 4'b1100);
  endtask

  // Feeds prog[0..len-1]; gap idle cycles before each word (random up to gap
  // when rand_gap). With noise, start and junk data toggle while in FILL.
  task automatic fill_words(input int len, input int gap, input bit rand_gap, input bit noise);
    for (int i = 0; i < len; i++) begin
      int g;
      g = rand_gap ? int'($urandom_range(0, gap)) : gap;
      for (int k = 0; k < g; k++) begin
        host_if.in_valid = 1'b0;
        if (noise) begin
          host_if.start    = 1'($urandom);
          host_if.prog_len = LEN_W'($urandom);
          host_if.in_data  = $urandom;
        end
        step();
      end
      check($sformatf("fill ready w%0d", i), host_if.in_ready, 1'b1);
      host_if.in_valid = 1'b1;
      host_if.in_data  = prog[i];
      host_if.start    = noise ? 1'($urandom) : 1'b0;
      host_if.prog_len = LEN_W'($urandom_range(1, DEPTH));
      step();
      clear_inputs();
    end
  endtask

  // Called at the first CLEAR cycle; compares every cycle through two RUN cycles.
  task automatic check_trace(input int len, input bit noise);
    int total;
    total = 2 * RST_CYCLES + len + 2;
    for (int j = 0; j < total; j++) begin
      logic [35:0] exp;
      if (j < RST_CYCLES)                   exp = {4'b1000, 32'h0};
      else if (j < RST_CYCLES + len)        exp = {4'b0100, prog[j - RST_CYCLES]};
      else if (j < 2 * RST_CYCLES + len)    exp = {4'b1000, 32'h0};
      else                                  exp = {4'b0010, 32'h0};
      check($sformatf("trace len%0d cyc%0d {rst,load,done,ready,instr}", len, j),
            {cpu_reset, cpu_load, done, host_if.in_ready, cpu_instr}, exp);
      if (noise) begin
        host_if.in_valid = 1'($urandom);
        host_if.in_data  = $urandom;
        host_if.prog_len = LEN_W'($urandom);
        // start is only ignored before RUN
        host_if.start    = (j < 2 * RST_CYCLES + len) ? 1'($urandom) : 1'b0;
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic full_load(input int len, input int gap, input bit rand_gap, input bit noise);
    issue_start(len);
    fill_words(len, gap, rand_gap, noise);
    check_trace(len, noise);
  endtask

  task automatic bad_start_in_run(input logic [LEN_W-1:0] len);
    host_if.start    = 1'b1;
    host_if.prog_len = len;
    step();
    host_if.start = 1'b0;
    check($sformatf("bad start in run len%0d {err,done,ready}", len),
          {err, done, host_if.in_ready}, 3'b110);
  endtask

  initial begin
    bit found;

    vecs[0] = '{1'b1, 6'd0,  1'b1, 1'b0};
    vecs[1] = '{1'b0, 6'd0,  1'b1, 1'b0};  // err is sticky
    vecs[2] = '{1'b1, 6'd33, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 6'd63, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 6'd1,  1'b0, 1'b1};  // valid start clears err

    clear_inputs();
    Reset = 1'b1;
    step();
    step();
    check("reset {rst,load,done,ready,err,instr}",
          {cpu_reset, cpu_load, done, host_if.in_ready, err, cpu_instr}, {5'b10000, 32'h0});
    Reset = 1'b0;
    step();
    check("idle after reset {rst,load,done,ready,err}",
          {cpu_reset, cpu_load, done, host_if.in_ready, err}, 5'b10000);

    // Length validation table, ending in FILL with a 1-word program.
    for (int i = 0; i < 5; i++) begin
      host_if.start    = vecs[i].start;
      host_if.prog_len = vecs[i].len;
      step();
      host_if.start = 1'b0;
      check($sformatf("badlen row%0d {err,ready,rst,done}", i),
            {err, host_if.in_ready, cpu_reset, done},
            {vecs[i].exp_err, vecs[i].exp_ready, 2'b10});
    end
    prog[0] = $urandom;
    fill_words(1, 0, 1'b0, 1'b0);
    check_trace(1, 1'b0);

    // Basic load.
    prog[0] = 32'h20010005;
    prog[1] = 32'h20020003;
    prog[2] = 32'h00221820;
    prog[3] = 32'hAC030000;
    full_load(4, 0, 1'b0, 1'b0);

    // Host stalls of 5 cycles between words.
    for (int i = 0; i < 3; i++) prog[i] = $urandom;
    full_load(3, 5, 1'b0, 1'b0);

    bad_start_in_run(6'd0);
    bad_start_in_run(6'd33);

    // Reset during the third STREAM cycle.
    for (int i = 0; i < 8; i++) prog[i] = $urandom;
    issue_start(8);
    fill_words(8, 0, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < RST_CYCLES + 2 && !found; k++) begin
      if (cpu_load) found = 1'b1;
      else          step();
    end
    check("stream begins within bound", found, 1'b1);
    step();
    step();
    check("third stream word", cpu_instr, prog[2]);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("reset mid-stream {rst,load,done,ready,err}",
          {cpu_reset, cpu_load, done, host_if.in_ready, err}, 5'b10000);
    repeat (3) step();
    check("cpu held in reset {rst,load,done}", {cpu_reset, cpu_load, done}, 3'b100);

    prog[0] = $urandom;
    prog[1] = $urandom;
    full_load(2, 0, 1'b0, 1'b0);

    // Reload from RUN with a full-depth program.
    for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    full_load(DEPTH, 0, 1'b0, 1'b0);

    // Ignored inputs: start/in_valid toggling in FILL, CLEAR, STREAM, BOOT, RUN.
    for (int i = 0; i < 5; i++) prog[i] = $urandom;
    full_load(5, 2, 1'b0, 1'b1);

    // Randomized loads.
    for (int it = 0; it < 6; it++) begin
      int len;
      len = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
      if (it % 2 == 1) bad_start_in_run(LEN_W'($urandom_range(DEPTH + 1, 63)));
      full_load(len, int'($urandom_range(0, 3)), 1'b1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
